// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if
// Bundles every signal between the decode front end and its neighbours:
// IF (PC handoff), instruction SRAM read data, EX (hold/flush and issue),
// the register file read ports and the forwarding sources.
//
// Handshake: IF->ID is a valid/ready pair, if_valid is valid and
// id_advance is ready; a PC is consumed on a clock edge where both are
// high (if_valid=0 with id_advance=1 loads a bubble). ID->EX uses ex_valid
// as valid and ~ex_hold as ready; while ex_hold=1 ID keeps presenting the
// same instruction and operands. flush overrides both sides.
//
// Modports:
//   slave  - the decode stage itself
//   master - the surrounding pipeline (or a testbench)
interface id_operand_stage_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2,
  parameter int PCW  = 32,
  parameter int CNTW = 16
);
  logic                 if_valid;
  logic [PCW-1:0]       if_pc;
  logic [31:0]          inst_rdata;
  logic                 ex_hold;
  logic                 flush;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*AW-1:0]   fwd_waddr;
  logic [NFWD*DW-1:0]   fwd_wdata;
  logic [NFWD-1:0]      fwd_is_load;
  logic [AW-1:0]        rf_raddr1;
  logic [AW-1:0]        rf_raddr2;
  logic [DW-1:0]        rf_rdata1;
  logic [DW-1:0]        rf_rdata2;
  logic                 id_advance;
  logic                 stallreq;
  logic                 ex_valid;
  logic [PCW-1:0]       id_pc;
  logic [31:0]          id_inst;
  logic [DW-1:0]        src1;
  logic [DW-1:0]        src2;
  logic [CNTW-1:0]      stall_cycles;

  modport slave (
    input  if_valid, if_pc, inst_rdata, ex_hold, flush,
           fwd_we, fwd_waddr, fwd_wdata, fwd_is_load,
           rf_rdata1, rf_rdata2,
    output rf_raddr1, rf_raddr2, id_advance, stallreq, ex_valid,
           id_pc, id_inst, src1, src2, stall_cycles
  );

  modport master (
    output if_valid, if_pc, inst_rdata, ex_hold, flush,
           fwd_we, fwd_waddr, fwd_wdata, fwd_is_load,
           rf_rdata1, rf_rdata2,
    input  rf_raddr1, rf_raddr2, id_advance, stallreq, ex_valid,
           id_pc, id_inst, src1, src2, stall_cycles
  );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage
// Decode-stage front end of the MIPS pipeline. Holds the IF->ID pipeline
// register, keeps the instruction word alive across stall/hold cycles
// (the synchronous SRAM only presents it for one cycle), resolves the rs/rt
// operands from the register file or NFWD forwarding sources, requests a
// stall on load-use hazards and counts stall cycles.
//
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - id_operand_stage_if.slave: IF/SRAM inputs, EX hold/flush,
//              forwarding sources, register file read ports, ID outputs
//              (id_advance, stallreq, ex_valid, id_pc, id_inst, src1/src2,
//              stall_cycles)
module id_operand_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2,
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input logic               clk,
  input logic               rst,
  id_operand_stage_if.slave bus
);

  typedef struct packed {
    logic          hazard;
    logic [DW-1:0] value;
  } operand_t;

  logic            id_valid_r;
  logic [PCW-1:0]  id_pc_r;
  logic [31:0]     inst_hold_r;
  logic            inst_latched_r;
  logic [CNTW-1:0] stall_cycles_r;

  logic [31:0]     id_inst;
  logic [AW-1:0]   rs_addr;
  logic [AW-1:0]   rt_addr;
  operand_t        op_rs;
  operand_t        op_rt;
  logic            stallreq;
  logic            id_advance;

  // Source index 0 is the youngest result. Scanning from the oldest source
  // down lets a younger match overwrite an older one, so an older load is
  // ignored whenever a younger writer of the same register exists.
  function automatic operand_t resolve(
    input logic [AW-1:0]      addr,
    input logic [DW-1:0]      rf_data,
    input logic [NFWD-1:0]    we,
    input logic [NFWD*AW-1:0] waddr,
    input logic [NFWD*DW-1:0] wdata,
    input logic [NFWD-1:0]    is_load
  );
    operand_t r;
    r.hazard = 1'b0;
    r.value  = rf_data;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (we[i] && (waddr[i*AW +: AW] == addr)) begin
        r.value  = wdata[i*DW +: DW];
        r.hazard = is_load[i];
      end
    end
    // Register 0 reads as zero and never waits, whatever is being written.
    if (addr == '0) begin
      r.value  = '0;
      r.hazard = 1'b0;
    end
    return r;
  endfunction

  // The SRAM word is only on inst_rdata during the first ID cycle; after
  // that the captured copy is used.
  assign id_inst = !id_valid_r     ? 32'h0 :
                   inst_latched_r  ? inst_hold_r : bus.inst_rdata;

  assign rs_addr = AW'(id_inst[25:21]);
  assign rt_addr = AW'(id_inst[20:16]);

  assign op_rs = resolve(rs_addr, bus.rf_rdata1, bus.fwd_we, bus.fwd_waddr,
                         bus.fwd_wdata, bus.fwd_is_load);
  assign op_rt = resolve(rt_addr, bus.rf_rdata2, bus.fwd_we, bus.fwd_waddr,
                         bus.fwd_wdata, bus.fwd_is_load);

  // Both fields are checked for every format; a spurious stall on an
  // immediate-format rt is accepted in exchange for no decode dependency.
  assign stallreq   = id_valid_r & (op_rs.hazard | op_rt.hazard);
  assign id_advance = ~bus.ex_hold & ~stallreq;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_r     <= 1'b0;
      id_pc_r        <= '0;
      inst_hold_r    <= 32'h0;
      inst_latched_r <= 1'b0;
    end else if (bus.flush) begin
      id_valid_r     <= 1'b0;
      inst_latched_r <= 1'b0;
    end else if (id_advance) begin
      id_valid_r     <= bus.if_valid;
      id_pc_r        <= bus.if_pc;
      inst_latched_r <= 1'b0;
    end else if (!inst_latched_r) begin
      // First held cycle: capture the word before the SRAM output moves on.
      inst_hold_r    <= bus.inst_rdata;
      inst_latched_r <= 1'b1;
    end
  end

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= '0;
    end else if (stallreq && (stall_cycles_r != {CNTW{1'b1}})) begin
      stall_cycles_r <= stall_cycles_r + CNTW'(1);
    end
  end

  assign bus.rf_raddr1    = rs_addr;
  assign bus.rf_raddr2    = rt_addr;
  assign bus.id_advance   = id_advance;
  assign bus.stallreq     = stallreq;
  assign bus.ex_valid     = id_valid_r & ~stallreq & ~bus.flush;
  assign bus.id_pc        = id_pc_r;
  assign bus.id_inst      = id_inst;
  assign bus.src1         = op_rs.value;
  assign bus.src2         = op_rt.value;
  assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage
// Directed scenarios for each feature of the decode front end, followed by
// a randomized run compared against a behavioural model of the stage and a
// long stall run that drives the stall counter into saturation.
module tb_id_operand_stage;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NFWD = 2;
  localparam int PCW  = 32;
  localparam int CNTW = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] rf_mem [32];

  id_operand_stage_if #(.DW(DW), .AW(AW), .NFWD(NFWD), .PCW(PCW), .CNTW(CNTW)) bus ();

  id_operand_stage #(.DW(DW), .AW(AW), .NFWD(NFWD), .PCW(PCW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file: combinational read of the bench-owned array.
  assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.if_valid    = 1'b0;
    bus.if_pc       = '0;
    bus.inst_rdata  = 32'h0;
    bus.ex_hold     = 1'b0;
    bus.flush       = 1'b0;
    bus.fwd_we      = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = '0;
    bus.fwd_is_load = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  // Presents pc to IF for one cycle, then puts the word on the SRAM bus;
  // returns in the instruction's first ID cycle.
  task automatic load_inst(input logic [31:0] pc, input logic [31:0] word);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    tick();
    bus.if_valid   = 1'b0;
    bus.if_pc      = '0;
    bus.inst_rdata = word;
  endtask

  task automatic set_load_src0(input logic [4:0] reg_a, input logic [31:0] data);
    bus.fwd_we      = 2'b01;
    bus.fwd_waddr   = {5'd0, reg_a};
    bus.fwd_wdata   = {32'h0, data};
    bus.fwd_is_load = 2'b01;
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_word;
  logic        m_first;
  int          m_cnt;

  logic [31:0] e_inst, e_src1, e_src2, e_pc;
  logic [4:0]  e_rs, e_rt;
  logic        e_stall, e_adv, e_exv;

  function automatic void ref_operand(input logic [4:0] a, output logic [31:0] v,
                                      output logic hz);
    v  = rf_mem[a];
    hz = 1'b0;
    if (a == 5'd0) begin
      v = 32'h0;
      return;
    end
    for (int i = 0; i < NFWD; i++) begin
      if (bus.fwd_we[i] && bus.fwd_waddr[i*AW +: AW] == a) begin
        v  = bus.fwd_wdata[i*DW +: DW];
        hz = bus.fwd_is_load[i];
        return;
      end
    end
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_word  = 32'h0;
    m_first = 1'b1;
    m_cnt   = 0;
  endfunction

  function automatic void model_eval();
    logic hz1, hz2;
    e_inst = !m_valid ? 32'h0 : (m_first ? bus.inst_rdata : m_word);
    e_rs   = e_inst[25:21];
    e_rt   = e_inst[20:16];
    ref_operand(e_rs, e_src1, hz1);
    ref_operand(e_rt, e_src2, hz2);
    e_stall = m_valid && (hz1 || hz2);
    e_adv   = !bus.ex_hold && !e_stall;
    e_exv   = m_valid && !e_stall && !bus.flush;
    e_pc    = m_pc;
  endfunction

  // Applies one clock edge using the inputs that were present before it.
  function automatic void model_tick();
    if (e_stall && m_cnt < 65535) m_cnt++;
    if (rst) begin
      model_reset();
    end else if (bus.flush) begin
      m_valid = 1'b0;
      m_first = 1'b1;
    end else if (e_adv) begin
      m_valid = bus.if_valid;
      m_pc    = bus.if_pc;
      m_first = 1'b1;
    end else if (m_first) begin
      m_word  = bus.inst_rdata;
      m_first = 1'b0;
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    settle();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %0h expected 0", bus.ex_valid); end
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stallreq: got %0h expected 0", bus.stallreq); end
    n_cmp++; if (bus.id_inst !== 32'h0) begin n_err++; $display("FAIL reset_id_inst: got %h expected 0", bus.id_inst); end
    n_cmp++; if (bus.id_advance !== 1'b1) begin n_err++; $display("FAIL reset_id_advance: got %0h expected 1", bus.id_advance); end
    n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc: got %h expected 0", bus.id_pc); end
    n_cmp++; if (bus.stall_cycles !== 16'h0) begin n_err++; $display("FAIL reset_stall_cycles: got %h expected 0", bus.stall_cycles); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    load_inst(32'h100, 32'h24020005);
    settle();
    n_cmp++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL fetch_ex_valid: got %0h expected 1", bus.ex_valid); end
    n_cmp++; if (bus.id_pc !== 32'h100) begin n_err++; $display("FAIL fetch_id_pc: got %h expected 100", bus.id_pc); end
    n_cmp++; if (bus.id_inst !== 32'h24020005) begin n_err++; $display("FAIL fetch_id_inst: got %h expected 24020005", bus.id_inst); end
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL fetch_stallreq: got %0h expected 0", bus.stallreq); end
    n_cmp++; if (bus.src2 !== rf_mem[2]) begin n_err++; $display("FAIL fetch_src2_rf: got %h expected %h", bus.src2, rf_mem[2]); end
    n_cmp++; if (bus.src1 !== 32'h0) begin n_err++; $display("FAIL fetch_src1_r0: got %h expected 0", bus.src1); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    load_inst(32'h104, 32'h00600000);  // rs = 3
    bus.fwd_we    = 2'b11;
    bus.fwd_waddr = {5'd3, 5'd3};
    bus.fwd_wdata = {32'h0000BBBB, 32'h0000AAAA};
    settle();
    n_cmp++; if (bus.src1 !== 32'hAAAA) begin n_err++; $display("FAIL fwd_both_src1: got %h expected aaaa", bus.src1); end
    bus.fwd_is_load = 2'b10;  // older load shadowed by younger ALU result
    #1;
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL fwd_old_load_stall: got %0h expected 0", bus.stallreq); end
    bus.fwd_is_load = 2'b01;
    #1;
    n_cmp++; if (bus.stallreq !== 1'b1) begin n_err++; $display("FAIL fwd_young_load_stall: got %0h expected 1", bus.stallreq); end
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL fwd_young_load_exv: got %0h expected 0", bus.ex_valid); end
    bus.fwd_is_load = 2'b00;
    bus.fwd_we      = 2'b10;
    #1;
    n_cmp++; if (bus.src1 !== 32'hBBBB) begin n_err++; $display("FAIL fwd_old_src1: got %h expected bbbb", bus.src1); end
  endtask

  task automatic test_r0();
    do_reset();
    load_inst(32'h110, 32'h00000020);  // rs = rt = 0
    bus.fwd_we      = 2'b01;
    bus.fwd_waddr   = {5'd0, 5'd0};
    bus.fwd_wdata   = {32'h0, 32'hFFFFFFFF};
    bus.fwd_is_load = 2'b01;
    settle();
    n_cmp++; if (bus.src1 !== 32'h0) begin n_err++; $display("FAIL r0_src1: got %h expected 0", bus.src1); end
    n_cmp++; if (bus.src2 !== 32'h0) begin n_err++; $display("FAIL r0_src2: got %h expected 0", bus.src2); end
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL r0_stallreq: got %0h expected 0", bus.stallreq); end
  endtask

  task automatic test_load_use();
    do_reset();
    load_inst(32'h108, 32'h00040000);  // rt = 4
    set_load_src0(5'd4, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++; if (bus.stallreq !== 1'b1) begin n_err++; $display("FAIL lu_stallreq[%0d]: got %0h expected 1", k, bus.stallreq); end
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_ex_valid[%0d]: got %0h expected 0", k, bus.ex_valid); end
      n_cmp++; if (bus.id_advance !== 1'b0) begin n_err++; $display("FAIL lu_id_advance[%0d]: got %0h expected 0", k, bus.id_advance); end
      n_cmp++; if (bus.id_inst !== 32'h00040000) begin n_err++; $display("FAIL lu_id_inst[%0d]: got %h expected 00040000", k, bus.id_inst); end
      tick();
      bus.inst_rdata = $urandom;
    end
    bus.fwd_is_load = 2'b00;
    settle();
    n_cmp++; if (bus.stall_cycles !== 16'd3) begin n_err++; $display("FAIL lu_stall_cycles: got %0d expected 3", bus.stall_cycles); end
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL lu_clear_stallreq: got %0h expected 0", bus.stallreq); end
    n_cmp++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL lu_clear_ex_valid: got %0h expected 1", bus.ex_valid); end
    n_cmp++; if (bus.src2 !== 32'h12345678) begin n_err++; $display("FAIL lu_clear_src2: got %h expected 12345678", bus.src2); end
    n_cmp++; if (bus.id_inst !== 32'h00040000) begin n_err++; $display("FAIL lu_clear_id_inst: got %h expected 00040000", bus.id_inst); end
  endtask

  task automatic test_hold_flush();
    do_reset();
    load_inst(32'h10C, 32'h8C450010);
    bus.ex_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (bus.id_inst !== 32'h8C450010) begin n_err++; $display("FAIL hold_id_inst[%0d]: got %h expected 8c450010", k, bus.id_inst); end
      n_cmp++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL hold_ex_valid[%0d]: got %0h expected 1", k, bus.ex_valid); end
      n_cmp++; if (bus.id_advance !== 1'b0) begin n_err++; $display("FAIL hold_id_advance[%0d]: got %0h expected 0", k, bus.id_advance); end
      tick();
      bus.inst_rdata = $urandom;
    end
    bus.ex_hold = 1'b0;
    bus.flush   = 1'b1;
    settle();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_cycle_ex_valid: got %0h expected 0", bus.ex_valid); end
    tick();
    bus.flush = 1'b0;
    settle();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL post_flush_ex_valid: got %0h expected 0", bus.ex_valid); end
    n_cmp++; if (bus.id_inst !== 32'h0) begin n_err++; $display("FAIL post_flush_id_inst: got %h expected 0", bus.id_inst); end
    n_cmp++; if (bus.id_pc !== 32'h10C) begin n_err++; $display("FAIL post_flush_id_pc: got %h expected 10c", bus.id_pc); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    load_inst(32'h300, 32'h00040000);
    set_load_src0(5'd4, 32'h55);
    tick();
    bus.flush = 1'b1;
    settle();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL fs_flush_ex_valid: got %0h expected 0", bus.ex_valid); end
    tick();
    bus.flush = 1'b0;
    settle();
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL fs_stallreq: got %0h expected 0", bus.stallreq); end
    n_cmp++; if (bus.id_inst !== 32'h0) begin n_err++; $display("FAIL fs_id_inst: got %h expected 0", bus.id_inst); end
    n_cmp++; if (bus.stall_cycles !== 16'd2) begin n_err++; $display("FAIL fs_stall_cycles: got %0d expected 2", bus.stall_cycles); end
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    load_inst(32'h400, 32'h00040000);
    set_load_src0(5'd4, 32'h66);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    n_cmp++; if (bus.stall_cycles !== 16'd0) begin n_err++; $display("FAIL rs_stall_cycles: got %0d expected 0", bus.stall_cycles); end
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL rs_ex_valid: got %0h expected 0", bus.ex_valid); end
    n_cmp++; if (bus.stallreq !== 1'b0) begin n_err++; $display("FAIL rs_stallreq: got %0h expected 0", bus.stallreq); end
    n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL rs_id_pc: got %h expected 0", bus.id_pc); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      w        = $urandom;
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      bus.inst_rdata  = w;
      bus.if_valid    = 1'($urandom_range(0, 1));
      bus.if_pc       = {$urandom_range(0, 65535), 2'b00};
      bus.ex_hold     = ($urandom_range(0, 3) == 0);
      bus.flush       = ($urandom_range(0, 15) == 0);
      rst             = ($urandom_range(0, 63) == 0);
      bus.fwd_we      = 2'($urandom_range(0, 3));
      bus.fwd_waddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.fwd_wdata   = {$urandom, $urandom};
      bus.fwd_is_load = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      settle();
      model_eval();
      n_cmp++; if (bus.ex_valid !== e_exv) begin n_err++; $display("FAIL rnd_ex_valid@%0d: got %0h expected %0h", c, bus.ex_valid, e_exv); end
      n_cmp++; if (bus.stallreq !== e_stall) begin n_err++; $display("FAIL rnd_stallreq@%0d: got %0h expected %0h", c, bus.stallreq, e_stall); end
      n_cmp++; if (bus.id_advance !== e_adv) begin n_err++; $display("FAIL rnd_id_advance@%0d: got %0h expected %0h", c, bus.id_advance, e_adv); end
      n_cmp++; if (bus.id_pc !== e_pc) begin n_err++; $display("FAIL rnd_id_pc@%0d: got %h expected %h", c, bus.id_pc, e_pc); end
      n_cmp++; if (bus.id_inst !== e_inst) begin n_err++; $display("FAIL rnd_id_inst@%0d: got %h expected %h", c, bus.id_inst, e_inst); end
      n_cmp++; if (bus.rf_raddr1 !== e_rs || bus.rf_raddr2 !== e_rt) begin n_err++; $display("FAIL rnd_raddr@%0d: got %0d/%0d expected %0d/%0d", c, bus.rf_raddr1, bus.rf_raddr2, e_rs, e_rt); end
      n_cmp++; if (bus.src1 !== e_src1) begin n_err++; $display("FAIL rnd_src1@%0d: got %h expected %h", c, bus.src1, e_src1); end
      n_cmp++; if (bus.src2 !== e_src2) begin n_err++; $display("FAIL rnd_src2@%0d: got %h expected %h", c, bus.src2, e_src2); end
      n_cmp++; if (int'(bus.stall_cycles) != m_cnt) begin n_err++; $display("FAIL rnd_stall_cycles@%0d: got %0d expected %0d", c, bus.stall_cycles, m_cnt); end
      tick();
      model_tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    load_inst(32'h500, 32'h00040000);
    set_load_src0(5'd4, 32'h77);
    for (int k = 0; k < 65534; k++) tick();
    settle();
    n_cmp++; if (bus.stall_cycles !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h expected fffe", bus.stall_cycles); end
    for (int k = 0; k < 7; k++) tick();
    settle();
    n_cmp++; if (bus.stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h expected ffff", bus.stall_cycles); end
    n_cmp++; if (bus.stallreq !== 1'b1) begin n_err++; $display("FAIL sat_stallreq: got %0h expected 1", bus.stallreq); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'hDEADBEEF;  // must never reach an operand
    test_reset();
    test_basic_fetch();
    test_fwd_priority();
    test_r0();
    test_load_use();
    test_hold_flush();
    test_flush_stall();
    test_rst_mid_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
